// File: rtl/bit_rx64.sv
// Serial frame receiver: start bit, 64 data bits, stop bit. Data goes into a 16 x 4-bit buffer.
// The buffer is held write-protected until the host acknowledges the frame.
module bit_rx64 (
  input  logic       tick,
  input  logic       clr,
  input  logic       din,
  input  logic       din_vld,
  input  logic       ack,
  input  logic [3:0] rd_a,
  output logic [3:0] rd_d,
  output logic [3:0] rg_a,
  output logic [1:0] bit_a,
  output logic       busy,
  output logic       full,
  output logic       done,
  output logic       frm_err,
  output logic       ovr
);

  typedef enum logic [1:0] {IDLE, RECV, STOP, FULL} state_t;

  state_t      state_reg, state_next;
  logic [5:0]  ptr_reg, ptr_next;
  logic        frm_err_reg, frm_err_next;
  logic        ovr_reg, ovr_next;
  logic        wr_en;
  logic        done_c;
  logic [15:0] wr_sel;
  logic [3:0]  rd_d_reg;
  logic [3:0]  mem [16];

  always_ff @(posedge tick) begin
    if (clr) begin
      state_reg   <= IDLE;
      ptr_reg     <= 6'd0;
      frm_err_reg <= 1'b0;
      ovr_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      frm_err_reg <= frm_err_next;
      ovr_reg     <= ovr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    frm_err_next = frm_err_reg;
    ovr_next     = ovr_reg;
    wr_en        = 1'b0;
    done_c       = 1'b0;
    case (state_reg)
      IDLE: begin
        // A valid 0 is just the idle line level; only a 1 opens a frame.
        if (din_vld && din) begin
          state_next   = RECV;
          ptr_next     = 6'd0;
          frm_err_next = 1'b0;
        end
      end
      RECV: begin
        if (din_vld) begin
          wr_en    = 1'b1;
          ptr_next = ptr_reg + 6'd1;
          if (ptr_reg == 6'd63) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (din_vld) begin
          if (din) begin
            state_next   = IDLE;
            frm_err_next = 1'b1;
          end else begin
            state_next = FULL;
            done_c     = 1'b1;
          end
        end
      end
      FULL: begin
        // A bit arriving with ack is still an overrun and is never a start bit.
        if (din_vld) begin
          ovr_next = 1'b1;
        end
        if (ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_wr_sel
      assign wr_sel[gi] = wr_en && (ptr_reg[5:2] == 4'(gi));
    end
  endgenerate

  // Reads see the pre-write contents because both updates land on the same edge.
  always_ff @(posedge tick) begin
    if (clr) begin
      rd_d_reg <= 4'h0;
      for (int i = 0; i < 16; i++) begin
        mem[i] <= 4'h0;
      end
    end else begin
      rd_d_reg <= mem[rd_a];
      for (int i = 0; i < 16; i++) begin
        if (wr_sel[i]) begin
          mem[i][ptr_reg[1:0]] <= din;
        end
      end
    end
  end

  assign rd_d    = rd_d_reg;
  assign rg_a    = ptr_reg[5:2];
  assign bit_a   = ptr_reg[1:0];
  assign busy    = (state_reg == RECV) || (state_reg == STOP);
  assign full    = (state_reg == FULL);
  assign done    = done_c && !clr;
  assign frm_err = frm_err_reg;
  assign ovr     = ovr_reg;

endmodule

// File: tb/tb_bit_rx64.sv
// Directed bench for bit_rx64: clean, gapped, bad-stop, overrun, reset and idle-noise frames.
module tb_bit_rx64;

  logic       tick = 1'b0;
  logic       clr = 1'b0;
  logic       din = 1'b0;
  logic       din_vld = 1'b0;
  logic       ack = 1'b0;
  logic [3:0] rd_a = 4'h0;
  logic [3:0] rd_d;
  logic [3:0] rg_a;
  logic [1:0] bit_a;
  logic       busy, full, done, frm_err, ovr;

  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  logic done_seen = 1'b0;

  bit_rx64 dut (
    .tick(tick), .clr(clr), .din(din), .din_vld(din_vld), .ack(ack),
    .rd_a(rd_a), .rd_d(rd_d), .rg_a(rg_a), .bit_a(bit_a), .busy(busy),
    .full(full), .done(done), .frm_err(frm_err), .ovr(ovr)
  );

  always #5 tick = ~tick;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // One tick: apply inputs, sample the combinational done mid-cycle, then cross the edge.
  task automatic drive(input logic d, input logic v, input logic a);
    din = d; din_vld = v; ack = a;
    @(negedge tick);
    done_seen = done;
    if (done === 1'b1) done_cnt++;
    @(posedge tick);
    #1;
    din = 1'b0; din_vld = 1'b0; ack = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    drive(1'b1, 1'b1, 1'b1);
    clr = 1'b0;
  endtask

  // Frame payload: register i holds value i, LSB first.
  function automatic logic data_bit(input int k);
    logic [3:0] nib;
    logic [1:0] pos;
    nib = 4'(k / 4);
    pos = 2'(k % 4);
    return nib[pos];
  endfunction

  task automatic send_frame(input logic stop_bit);
    drive(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 64; k++) drive(data_bit(k), 1'b1, 1'b0);
    drive(stop_bit, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    do_clr();
    checks++; if (rg_a !== 4'h0) begin errors++; $display("FAIL reset_rg_a: got %h required 0", rg_a); end
    checks++; if (bit_a !== 2'h0) begin errors++; $display("FAIL reset_bit_a: got %h required 0", bit_a); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b required 0", full); end
    checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done_seen); end
    checks++; if (frm_err !== 1'b0) begin errors++; $display("FAIL reset_frm_err: got %b required 0", frm_err); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b required 0", ovr); end
    checks++; if (rd_d !== 4'h0) begin errors++; $display("FAIL reset_rd_d: got %h required 0", rd_d); end
    drive(1'b1, 1'b1, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_first_start: busy got %b required 1", busy); end
    do_clr();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_clr_priority: busy got %b required 0", busy); end
    $display("test_reset complete");
  endtask

  task automatic test_idle_noise();
    do_clr();
    done_cnt = 0;
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noise_busy: got %b required 0", busy); end
    checks++; if ({rg_a, bit_a} !== 6'd0) begin errors++; $display("FAIL noise_ptr: got %0d required 0", {rg_a, bit_a}); end
    checks++; if ({full, frm_err, ovr} !== 3'b000) begin errors++; $display("FAIL noise_flags: got %b required 000", {full, frm_err, ovr}); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL noise_done: got %0d required 0", done_cnt); end
    drive(1'b0, 1'b0, 1'b1);
    checks++; if ({busy, full, ovr} !== 3'b000) begin errors++; $display("FAIL noise_ack: got %b required 000", {busy, full, ovr}); end
    $display("test_idle_noise complete");
  endtask

  task automatic test_clean_frame();
    done_cnt = 0;
    drive(1'b1, 1'b1, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clean_start_busy: got %b required 1", busy); end
    for (int k = 0; k < 64; k++) begin
      drive(data_bit(k), 1'b1, (k == 10) ? 1'b1 : 1'b0);
      if (k == 36) begin
        checks++; if ({rg_a, bit_a} !== {4'h9, 2'h1}) begin errors++; $display("FAIL clean_ptr37: got rg %h bit %h required rg 9 bit 1", rg_a, bit_a); end
      end
    end
    checks++; if ({busy, full, rg_a, bit_a} !== {1'b1, 1'b0, 6'd0}) begin errors++; $display("FAIL clean_stop_state: got busy %b full %b ptr %0d required 1 0 0", busy, full, {rg_a, bit_a}); end
    drive(1'b0, 1'b1, 1'b0);
    checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL clean_done: got %b required 1", done_seen); end
    checks++; if ({full, busy} !== 2'b10) begin errors++; $display("FAIL clean_full: got full %b busy %b required 1 0", full, busy); end
    rd_a = 4'h5;
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL clean_done_pulse: got %b required 0", done_seen); end
    checks++; if (rd_d !== 4'h5) begin errors++; $display("FAIL clean_rd5: got %h required 5", rd_d); end
    rd_a = 4'hF;
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (rd_d !== 4'hF) begin errors++; $display("FAIL clean_rdF: got %h required f", rd_d); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL clean_done_count: got %0d required 1", done_cnt); end
    $display("test_clean_frame complete");
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
    checks++; if ({ovr, full} !== 2'b11) begin errors++; $display("FAIL ovr_set: got ovr %b full %b required 1 1", ovr, full); end
    rd_a = 4'h5;
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (rd_d !== 4'h5) begin errors++; $display("FAIL ovr_rd5: got %h required 5", rd_d); end
    rd_a = 4'h0;
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (rd_d !== 4'h0) begin errors++; $display("FAIL ovr_rd0: got %h required 0", rd_d); end
    drive(1'b0, 1'b0, 1'b1);
    checks++; if ({full, ovr, busy} !== 3'b010) begin errors++; $display("FAIL ovr_ack: got full %b ovr %b busy %b required 0 1 0", full, ovr, busy); end
    $display("test_overrun complete");
  endtask

  task automatic test_ack_with_bit();
    do_clr();
    send_frame(1'b0);
    checks++; if ({full, ovr} !== 2'b10) begin errors++; $display("FAIL ackbit_full: got full %b ovr %b required 1 0", full, ovr); end
    drive(1'b1, 1'b1, 1'b1);
    checks++; if ({ovr, full, busy} !== 3'b100) begin errors++; $display("FAIL ackbit_state: got ovr %b full %b busy %b required 1 0 0", ovr, full, busy); end
    $display("test_ack_with_bit complete");
  endtask

  task automatic test_gapped();
    int ticks;
    int done_tick;
    int exp_ptr;
    logic b;
    do_clr();
    ticks = 0; done_tick = -1; exp_ptr = 0;
    for (int n = 0; n < 66; n++) begin
      b = (n == 0) ? 1'b1 : (n == 65) ? 1'b0 : data_bit(n - 1);
      drive(1'b0, 1'b0, 1'b0);
      ticks++;
      checks++; if ({rg_a, bit_a} !== 6'(exp_ptr)) begin errors++; $display("FAIL gap_hold_%0d: got ptr %0d required %0d", n, {rg_a, bit_a}, exp_ptr); end
      drive(b, 1'b1, 1'b0);
      ticks++;
      if (done_seen === 1'b1) done_tick = ticks;
      if (n >= 1 && n <= 64) exp_ptr = n % 64;
    end
    checks++; if (done_tick !== 132) begin errors++; $display("FAIL gap_done_tick: got %0d required 132", done_tick); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL gap_full: got %b required 1", full); end
    for (int i = 0; i < 16; i++) begin
      rd_a = 4'(i);
      drive(1'b0, 1'b0, 1'b0);
      checks++; if (rd_d !== 4'(i)) begin errors++; $display("FAIL gap_mem_%0d: got %h required %h", i, rd_d, 4'(i)); end
    end
    $display("test_gapped complete");
  endtask

  task automatic test_bad_stop();
    drive(1'b0, 1'b0, 1'b1);
    done_cnt = 0;
    send_frame(1'b1);
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL bad_done: got %0d required 0", done_cnt); end
    checks++; if ({full, frm_err, busy} !== 3'b010) begin errors++; $display("FAIL bad_flags: got full %b frm_err %b busy %b required 0 1 0", full, frm_err, busy); end
    drive(1'b0, 1'b1, 1'b0);
    checks++; if (frm_err !== 1'b1) begin errors++; $display("FAIL bad_sticky: got %b required 1", frm_err); end
    drive(1'b1, 1'b1, 1'b0);
    checks++; if ({frm_err, busy} !== 2'b01) begin errors++; $display("FAIL bad_restart: got frm_err %b busy %b required 0 1", frm_err, busy); end
    $display("test_bad_stop complete");
  endtask

  task automatic test_reset_mid_frame();
    do_clr();
    drive(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 37; k++) drive(data_bit(k), 1'b1, 1'b0);
    checks++; if ({rg_a, bit_a} !== {4'h9, 2'h1}) begin errors++; $display("FAIL mid_ptr37: got rg %h bit %h required rg 9 bit 1", rg_a, bit_a); end
    do_clr();
    checks++; if ({rg_a, bit_a, busy} !== 7'd0) begin errors++; $display("FAIL mid_clr: got rg %h bit %h busy %b required 0 0 0", rg_a, bit_a, busy); end
    for (int i = 0; i < 16; i++) begin
      rd_a = 4'(i);
      drive(1'b0, 1'b0, 1'b0);
      checks++; if (rd_d !== 4'h0) begin errors++; $display("FAIL mid_mem_%0d: got %h required 0", i, rd_d); end
    end
    done_cnt = 0;
    send_frame(1'b0);
    checks++; if ({done_cnt == 1, full} !== 2'b11) begin errors++; $display("FAIL mid_refill: got done_cnt %0d full %b required 1 1", done_cnt, full); end
    rd_a = 4'hA;
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (rd_d !== 4'hA) begin errors++; $display("FAIL mid_rdA: got %h required a", rd_d); end
    $display("test_reset_mid_frame complete");
  endtask

  initial begin
    test_reset();
    test_idle_noise();
    test_clean_frame();
    test_overrun();
    test_ack_with_bit();
    test_gapped();
    test_bad_stop();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
